neuron_lut_loader: RTL and testbench

- Runtime-programmable replacement for a fixed neuron truth-table ROM: IN_W-bit activation in, OUT_W-bit activation out.
- A host streams the truth table in, one entry per beat, into a shadow table. On the final beat the shadow table is committed atomically to the active table.
- Lookups run continuously against the active table, so the fabric can be reprogrammed without halting inference.
- Sits between the configuration controller and a layer's neuron array.

---
 rtl/neuron_lut_loader.sv | 138 +++++++++++++
 tb/tb_neuron_lut_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_lut_loader.sv
// Runtime-loadable neuron truth table: streamed shadow table, atomic commit to
// the active table, and a continuously running 1-cycle lookup path.
module neuron_lut_loader #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic [OUT_W-1:0] cfg_data,
  output logic             cfg_ready,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic             armed,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data
);

  localparam int unsigned DEPTH = 2 ** IN_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [IN_W-1:0]  r_cnt;
  logic [IN_W-1:0]  w_cnt_next;
  logic             w_shadow_we;
  logic             w_commit;
  logic             w_restart;

  logic             r_cfg_ready;
  logic             r_cfg_done;
  logic             r_cfg_err;
  logic             r_armed;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_data;

  logic [OUT_W-1:0] r_shadow [DEPTH];
  logic [OUT_W-1:0] r_active [DEPTH];

  // Load sequencing: a restart in LOAD outranks a simultaneous beat
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_shadow_we  = 1'b0;
    w_commit     = 1'b0;
    w_restart    = 1'b0;
    case (r_state)
      IDLE: begin
        if (cfg_start) begin
          w_state_next = LOAD;
          w_cnt_next   = '0;
        end
      end
      LOAD: begin
        if (cfg_start) begin
          w_cnt_next = '0;
          w_restart  = 1'b1;
        end else if (cfg_valid) begin
          w_shadow_we = 1'b1;
          w_cnt_next  = r_cnt + IN_W'(1);
          if (r_cnt == IN_W'(DEPTH - 1)) begin
            w_state_next = COMMIT;
          end
        end
      end
      COMMIT: begin
        w_commit     = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cfg_ready <= 1'b0;
      r_cfg_done  <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_cfg_ready <= (w_state_next == LOAD);
      r_cfg_done  <= w_commit;
      r_cfg_err   <= w_restart;
    end
  end

  // Shadow capture and whole-table commit on a single edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '{default: '0};
      r_active <= '{default: '0};
      r_armed  <= 1'b0;
    end else begin
      if (w_shadow_we) begin
        r_shadow[r_cnt] <= cfg_data;
      end
      if (w_commit) begin
        r_active <= r_shadow;
        r_armed  <= 1'b1;
      end
    end
  end

  // Lookup reads pre-commit active/armed when it coincides with a commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_out_data <= r_armed ? r_active[in_data] : '0;
      end
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign cfg_done  = r_cfg_done;
  assign cfg_err   = r_cfg_err;
  assign armed     = r_armed;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_neuron_lut_loader.sv
// Self-checking bench for neuron_lut_loader: directed scenarios plus random
// load/lookup traffic compared cycle by cycle with a table-level model.
module tb_neuron_lut_loader;

  localparam int unsigned IN_W  = 4;
  localparam int unsigned OUT_W = 2;
  localparam int unsigned DEPTH = 2 ** IN_W;

  logic             clk;
  logic             rst_n;
  logic             cfg_start;
  logic             cfg_valid;
  logic [OUT_W-1:0] cfg_data;
  logic             cfg_ready;
  logic             cfg_done;
  logic             cfg_err;
  logic             armed;
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;

  neuron_lut_loader #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .armed(armed),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int n_done_seen;

  // Reference model: a host-visible view of the loader (loading / beat index / commit owed)
  bit   m_loading;
  bit   m_commit_due;
  int   m_beat;
  int   m_shadow [DEPTH];
  int   m_active [DEPTH];
  bit   m_armed;
  bit   e_ready, e_done, e_err, e_ov;
  int   e_od;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_loading = 0; m_commit_due = 0; m_beat = 0; m_armed = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
    end
    e_ready = 0; e_done = 0; e_err = 0; e_ov = 0; e_od = 0;
  endtask

  task automatic model_step(input bit st, input bit vl, input int dat, input bit iv, input int ia);
    e_ov   = iv;
    if (iv) e_od = m_armed ? m_active[ia] : 0;
    e_done = 0;
    e_err  = 0;
    if (m_commit_due) begin
      for (int i = 0; i < int'(DEPTH); i++) m_active[i] = m_shadow[i];
      m_armed = 1; e_done = 1; m_commit_due = 0;
    end else if (m_loading) begin
      if (st) begin
        e_err = 1; m_beat = 0;
      end else if (vl) begin
        m_shadow[m_beat] = dat;
        if (m_beat == int'(DEPTH) - 1) begin
          m_loading = 0; m_commit_due = 1; m_beat = 0;
        end else begin
          m_beat++;
        end
      end
    end else if (st) begin
      m_loading = 1; m_beat = 0;
    end
    e_ready = m_loading;
  endtask

  // One clock: apply inputs, advance model on the edge, compare 1 time unit later
  task automatic cycle(input bit st, input bit vl, input int dat, input bit iv, input int ia);
    cfg_start = st;
    cfg_valid = vl;
    cfg_data  = OUT_W'(dat);
    in_valid  = iv;
    in_data   = IN_W'(ia);
    @(posedge clk);
    model_step(st, vl, dat, iv, ia);
    #1;
    if (cfg_done === 1'b1) n_done_seen++;
    check("cfg_ready", 8'(cfg_ready), 8'(e_ready));
    check("cfg_done",  8'(cfg_done),  8'(e_done));
    check("cfg_err",   8'(cfg_err),   8'(e_err));
    check("armed",     8'(armed),     8'(m_armed));
    check("out_valid", 8'(out_valid), 8'(e_ov));
    check("out_data",  8'(out_data),  8'(e_od));
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic load_pattern(input int mode, input int constval, input bit gapped);
    int i;
    cycle(1, 0, 0, 0, 0);
    i = 0;
    while (i < int'(DEPTH)) begin
      if (gapped) cycle(0, 0, 3, 1, $urandom_range(0, 15));
      cycle(0, 1, (mode == 0) ? (i % 4) : constval, 1, $urandom_range(0, 15));
      i++;
    end
  endtask

  task automatic lookup(input int addr, input int exp_val, input string tag);
    cycle(0, 0, 0, 1, addr);
    check(tag, 8'(out_data), 8'(exp_val));
  endtask

  task automatic wait_done(input int budget);
    int t;
    t = 0;
    while (cfg_done !== 1'b1 && t < budget) begin
      cycle(0, 0, 0, 0, 0);
      t++;
    end
    if (t >= budget) check("done_timeout", 8'(cfg_done), 8'd1);
  endtask

  initial begin
    int ready_cycles;
    int lookup_bad;
    int coll_stage;
    n_vec = 0; n_err = 0; n_done_seen = 0;
    cfg_start = 0; cfg_valid = 0; cfg_data = '0; in_valid = 0; in_data = '0;
    rst_n = 0;
    model_reset();
    #22;
    rst_n = 1;
    @(negedge clk);

    // Reset then lookup
    check("rst_ready", 8'(cfg_ready), 8'd0);
    check("rst_armed", 8'(armed), 8'd0);
    lookup(5, 0, "rst_lookup");
    check("rst_ov", 8'(out_valid), 8'd1);

    // Full back-to-back load, counting cfg_ready cycles
    ready_cycles = 0;
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (cfg_ready === 1'b1) ready_cycles++;
      cycle(0, 1, i % 4, 0, 0);
    end
    if (cfg_ready === 1'b1) ready_cycles++;
    check("ready_cycles", 8'(ready_cycles), 8'd16);
    cycle(0, 0, 0, 0, 0);
    check("done_2cyc", 8'(cfg_done), 8'd1);
    lookup(7, 3, "full_0111");
    lookup(10, 2, "full_1010");
    lookup(12, 0, "full_1100");

    // Gapped load reaches same table
    load_pattern(0, 0, 1);
    wait_done(8);
    lookup(7, 3, "gap_0111");
    lookup(10, 2, "gap_1010");
    lookup(13, 1, "gap_1101");

    // Restart after 7 beats
    n_done_seen = 0;
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cycle(0, 1, 3, 0, 0);
    cycle(1, 1, 3, 0, 0);
    check("restart_err", 8'(cfg_err), 8'd1);
    for (int i = 0; i < int'(DEPTH); i++) cycle(0, 1, 1, 0, 0);
    idle_cycles(4);
    check("restart_ndone", 8'(n_done_seen), 8'd1);
    lookup_bad = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      cycle(0, 0, 0, 1, i);
      if (out_data !== 2'b01) lookup_bad++;
    end
    check("restart_all01", 8'(lookup_bad), 8'd0);

    // Commit/lookup collision: table A=10, reload B=01 with lookups of 0 held
    load_pattern(1, 2, 0);
    wait_done(8);
    cycle(1, 0, 0, 1, 0);
    for (int i = 0; i < int'(DEPTH); i++) cycle(0, 1, 1, 1, 0);
    coll_stage = 0;
    for (int t = 0; t < 6 && coll_stage < 2; t++) begin
      cycle(0, 0, 0, 1, 0);
      if (coll_stage == 1) begin
        check("coll_new", 8'(out_data), 8'd1);
        coll_stage = 2;
      end else if (cfg_done === 1'b1) begin
        check("coll_old", 8'(out_data), 8'd2);
        coll_stage = 1;
      end
    end
    check("coll_seen", 8'(coll_stage), 8'd2);

    // Async reset mid-load after 9 beats
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cycle(0, 1, 3, 1, 5);
    #2;
    rst_n = 0;
    #1;
    check("arst_ready", 8'(cfg_ready), 8'd0);
    check("arst_armed", 8'(armed), 8'd0);
    check("arst_ov", 8'(out_valid), 8'd0);
    check("arst_od", 8'(out_data), 8'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    lookup(3, 0, "arst_lookup");
    check("arst_armed2", 8'(armed), 8'd0);

    // Random traffic: loads with gaps, restarts, and concurrent lookups
    for (int r = 0; r < 1500; r++) begin
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 15));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
